// File: rtl/fetch_redirect_unit_pkg.sv
// Shared opcode and pc-select encodings for the fetch/decode boundary.
// Imported by the redirect unit and the fetch stage.
package fetch_redirect_unit_pkg;

  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_BEQZ = 4'b1000;
  localparam logic [3:0] OP_BNEZ = 4'b1001;

  localparam logic [1:0] PC_SRC_NPC = 2'b00;
  localparam logic [1:0] PC_SRC_J   = 2'b01;
  localparam logic [1:0] PC_SRC_I   = 2'b10;
  localparam logic [1:0] PC_SRC_RET = 2'b11;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

endpackage

// File: rtl/fetch_redirect_unit_ras.sv
// Circular return-address stack with saturating occupancy count.
// A push when full overwrites the oldest entry.
module return_address_stack #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] push_data,
  output logic [15:0] top,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;
  logic          full;
  logic [PW-1:0] top_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top_idx = ptr - PW'(1);
  assign top     = empty ? 16'h0000 : mem[top_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF/ID register plus decode-stage control-flow resolution.
// Drives fetch pc_src/stall/kill and owns the return-address stack.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int          RAS_DEPTH = 8,
  parameter logic [15:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] if_instruction,
  input  logic [15:0] if_npc,
  input  logic [15:0] rs_value,
  input  logic        rs_ready,
  input  logic        hold_in,
  output logic [1:0]  pc_src,
  output logic [15:0] j_target,
  output logic [15:0] i_target,
  output logic [15:0] ret_target,
  output logic        stall,
  output logic        kill,
  output logic [15:0] id_instr,
  output logic [15:0] id_npc,
  output logic        id_valid,
  output logic        ras_underflow
);

  logic [3:0] op;
  logic       is_jmp, is_call, is_ret;
  logic       is_beqz, is_bnez;
  logic       need_rs, taken;
  logic       push, pop, ras_empty;

  assign op      = id_instr[15:12];
  assign is_jmp  = id_valid && op == OP_JMP;
  assign is_call = id_valid && op == OP_CALL;
  assign is_ret  = id_valid && op == OP_RET;
  assign is_beqz = id_valid && op == OP_BEQZ;
  assign is_bnez = id_valid && op == OP_BNEZ;

  assign need_rs = (is_beqz || is_bnez) && !rs_ready;
  assign stall   = hold_in || need_rs;
  assign taken   = (is_beqz && rs_value == 16'h0)
                || (is_bnez && rs_value != 16'h0);

  assign j_target = {id_npc[15:12], id_instr[11:0]};
  assign i_target = id_npc + {{10{id_instr[5]}}, id_instr[5:0]};

  always_comb begin
    pc_src = PC_SRC_NPC;
    kill   = 1'b0;
    if (!stall) begin
      unique case (1'b1)
        is_jmp, is_call: begin
          pc_src = PC_SRC_J;
          kill   = 1'b1;
        end
        is_ret: begin
          pc_src = PC_SRC_RET;
          kill   = 1'b1;
        end
        taken: begin
          pc_src = PC_SRC_I;
          kill   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign push = !stall && is_call;
  assign pop  = !stall && is_ret;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_instr <= NOP_WORD;
      id_npc   <= 16'h0000;
      id_valid <= 1'b0;
    end else if (!stall) begin
      if (kill) begin
        id_instr <= NOP_WORD;
        id_npc   <= 16'h0000;
        id_valid <= 1'b0;
      end else begin
        id_instr <= if_instruction;
        id_npc   <= if_npc;
        id_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ras_underflow <= 1'b0;
    else if (pop && ras_empty) ras_underflow <= 1'b1;
  end

  return_address_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .push_data(id_npc),
    .top      (ret_target),
    .empty    (ras_empty)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed-vector bench for fetch_redirect_unit.
// Inputs change 1ns after posedge; outputs checked mid-cycle.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] if_instruction, if_npc, rs_value;
  logic        rs_ready, hold_in;
  logic [1:0]  pc_src;
  logic [15:0] j_target, i_target, ret_target;
  logic        stall, kill;
  logic [15:0] id_instr, id_npc;
  logic        id_valid, ras_underflow;

  int compared = 0;
  int mismatched = 0;

  fetch_redirect_unit #(.RAS_DEPTH(8), .NOP_WORD(16'h0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .if_instruction(if_instruction),
    .if_npc        (if_npc),
    .rs_value      (rs_value),
    .rs_ready      (rs_ready),
    .hold_in       (hold_in),
    .pc_src        (pc_src),
    .j_target      (j_target),
    .i_target      (i_target),
    .ret_target    (ret_target),
    .stall         (stall),
    .kill          (kill),
    .id_instr      (id_instr),
    .id_npc        (id_npc),
    .id_valid      (id_valid),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [15:0] ins, input logic [15:0] npc);
    if_instruction = ins;
    if_npc = npc;
  endtask

  initial begin
    reset_n = 1'b0;
    fetch(16'h0000, 16'h0000);
    rs_value = 16'h0; rs_ready = 1'b1; hold_in = 1'b0;
    #12;
    check("rst_valid", 16'(id_valid), 16'h0);
    check("rst_instr", id_instr, 16'h0000);
    check("rst_npc", id_npc, 16'h0000);
    check("rst_pcsrc", 16'(pc_src), 16'h0);
    check("rst_stall", 16'(stall), 16'h0);
    check("rst_kill", 16'(kill), 16'h0);
    check("rst_ret", ret_target, 16'h0000);
    reset_n = 1'b1;

    // sequential ALU words
    fetch(16'h0123, 16'd1); tick();
    check("seq1_instr", id_instr, 16'h0123);
    check("seq1_npc", id_npc, 16'd1);
    check("seq1_valid", 16'(id_valid), 16'h1);
    check("seq1_pcsrc", 16'(pc_src), 16'h0);
    fetch(16'h0456, 16'd2); tick();
    check("seq2_instr", id_instr, 16'h0456);
    check("seq2_kill", 16'(kill), 16'h0);
    fetch(16'h0789, 16'd3); tick();
    check("seq3_instr", id_instr, 16'h0789);
    check("seq3_npc", id_npc, 16'd3);

    // JMP with one-bubble penalty
    fetch(16'hC005, 16'h1003); tick();
    check("jmp_target", j_target, 16'h1005);
    check("jmp_pcsrc", 16'(pc_src), 16'h1);
    check("jmp_kill", 16'(kill), 16'h1);
    fetch(16'h0AAA, 16'h1004); tick();
    check("jmp_bub_valid", 16'(id_valid), 16'h0);
    check("jmp_bub_instr", id_instr, 16'h0000);
    check("jmp_bub_kill", 16'(kill), 16'h0);
    check("jmp_bub_pcsrc", 16'(pc_src), 16'h0);
    fetch(16'h0BBB, 16'h1006); tick();
    check("jmp_tgt_instr", id_instr, 16'h0BBB);
    check("jmp_tgt_npc", id_npc, 16'h1006);

    // BEQZ waiting on rs, then taken backward
    rs_ready = 1'b0;
    fetch(16'h803E, 16'd20); tick();
    check("beqz_stall0", 16'(stall), 16'h1);
    check("beqz_kill0", 16'(kill), 16'h0);
    check("beqz_pcsrc0", 16'(pc_src), 16'h0);
    fetch(16'h0CCC, 16'd21); tick();
    check("beqz_stall1", 16'(stall), 16'h1);
    check("beqz_held", id_instr, 16'h803E);
    check("beqz_held_npc", id_npc, 16'd20);
    rs_ready = 1'b1; rs_value = 16'h0000; #1;
    check("beqz_stall2", 16'(stall), 16'h0);
    check("beqz_pcsrc", 16'(pc_src), 16'h2);
    check("beqz_itgt", i_target, 16'd18);
    check("beqz_kill", 16'(kill), 16'h1);
    fetch(16'h0DDD, 16'd22); tick();
    check("beqz_bubble", 16'(id_valid), 16'h0);

    // BNEZ not taken when rs is zero
    fetch(16'h9201, 16'd30); tick();
    check("bnez_nt_pcsrc", 16'(pc_src), 16'h0);
    check("bnez_nt_kill", 16'(kill), 16'h0);
    rs_value = 16'h0004; #1;
    check("bnez_t_pcsrc", 16'(pc_src), 16'h2);
    check("bnez_t_itgt", i_target, 16'd31);
    rs_value = 16'h0000;
    fetch(16'h0000, 16'd31); tick();

    // CALL then RET
    fetch(16'hD000, 16'h0010); tick();
    check("call_pcsrc", 16'(pc_src), 16'h1);
    check("call_kill", 16'(kill), 16'h1);
    check("call_jtgt", j_target, 16'h0000);
    fetch(16'h0111, 16'h0001); tick();
    check("call_ret_top", ret_target, 16'h0010);
    fetch(16'hE000, 16'h0002); tick();
    check("ret_pcsrc", 16'(pc_src), 16'h3);
    check("ret_tgt", ret_target, 16'h0010);
    check("ret_kill", 16'(kill), 16'h1);
    fetch(16'h0222, 16'h0003); tick();
    check("ret_empty", ret_target, 16'h0000);
    check("ret_noufl", 16'(ras_underflow), 16'h0);

    // nine CALLs into an 8-deep stack
    for (int i = 1; i <= 9; i++) begin
      fetch(16'hD000, 16'(i)); tick();
      check("call9_kill", 16'(kill), 16'h1);
      fetch(16'h0000, 16'h0000); tick();
    end
    check("call9_top", ret_target, 16'd9);
    for (int k = 0; k < 9; k++) begin
      fetch(16'hE000, 16'h0040); tick();
      check("ret9_pcsrc", 16'(pc_src), 16'h3);
      check("ret9_tgt", ret_target, (k < 8) ? 16'(9 - k) : 16'h0000);
      check("ret9_ufl_pre", 16'(ras_underflow), 16'h0);
      fetch(16'h0000, 16'h0000); tick();
    end
    check("ret9_ufl", 16'(ras_underflow), 16'h1);
    check("ret9_empty", ret_target, 16'h0000);

    // hold_in over a JMP, then async reset mid-redirect
    fetch(16'hC007, 16'h2001); tick();
    hold_in = 1'b1; #1;
    check("hold_stall", 16'(stall), 16'h1);
    check("hold_kill", 16'(kill), 16'h0);
    check("hold_pcsrc", 16'(pc_src), 16'h0);
    fetch(16'h0EEE, 16'h2002); tick();
    check("hold_id", id_instr, 16'hC007);
    check("hold_kill2", 16'(kill), 16'h0);
    hold_in = 1'b0; #1;
    check("unhold_kill", 16'(kill), 16'h1);
    check("unhold_pcsrc", 16'(pc_src), 16'h1);
    check("unhold_jtgt", j_target, 16'h2007);
    reset_n = 1'b0; #1;
    check("arst_valid", 16'(id_valid), 16'h0);
    check("arst_ufl", 16'(ras_underflow), 16'h0);
    check("arst_instr", id_instr, 16'h0000);
    check("arst_kill", 16'(kill), 16'h0);
    tick();
    reset_n = 1'b1;
    fetch(16'h0321, 16'h0005); tick();
    check("post_instr", id_instr, 16'h0321);
    check("post_ret", ret_target, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Consumer end of the fetch interface: captures fetched instruction/NPC into the IF/ID register.
- Resolves control flow (JMP, CALL, RET, BEQZ, BNEZ) in decode.
- Drives the fetch stage's pc_src, stall, kill and the three target buses.
- Maintains a circular return-address stack (RAS) for CALL/RET.

Parameters:
- RAS_DEPTH, 8, number of return-address entries (power of two, ≥2).
- NOP_WORD, 16'h0000, encoding loaded into the IF/ID register as a bubble.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- if_instruction  in  16  instruction from fetch.
- if_npc  in  16  PC+1 of that instruction.
- rs_value  in  16  register-file value of the ID instruction's rs field [11:9].
- rs_ready  in  1  rs_value is hazard-free this cycle.
- hold_in  in  1  downstream stall request.
- pc_src  out  2  00 NPC, 01 J target, 10 I target, 11 return address.
- j_target  out  16  {id_npc[15:12], id_instr[11:0]}.
- i_target  out  16  id_npc + sign-extended id_instr[5:0], modulo 2^16.
- ret_target  out  16  RAS top entry (0 when empty).
- stall  out  1  hold fetch PC.
- kill  out  1  squash wrong-path fetch.
- id_instr  out  16  IF/ID instruction.
- id_npc  out  16  IF/ID NPC.
- id_valid  out  1  IF/ID holds a real instruction.
- ras_underflow  out  1  sticky: RET executed with empty RAS.

Behaviour:
- Opcodes in [15:12]:
  - 1100 JMP
  - 1101 CALL
  - 1110 RET
  - 1000 BEQZ (taken if rs_value==0)
  - 1001 BNEZ (taken if rs_value!=0)
  - all other opcodes: no control-flow effect.
- Reset (asynchronous, reset_n=0):
  - id_instr=NOP_WORD, id_npc=0, id_valid=0.
  - RAS pointer=0, count=0, entries=0, ras_underflow=0.
  - Combinational outputs follow from this state: pc_src=00, stall=0, kill=0.
- need_rs: id_valid and opcode ∈ {BEQZ, BNEZ} and rs_ready=0.
- stall = hold_in | need_rs.
- While stall:
  - pc_src=00, kill=0.
  - IF/ID register and RAS unchanged.
- Without stall, if id_valid:
  - JMP: pc_src=01, kill=1.
  - CALL: pc_src=01, kill=1; push id_npc.
  - RET: pc_src=11, kill=1; pop.
  - Taken branch: pc_src=10, kill=1.
  - Otherwise: pc_src=00, kill=0.
- pc_src, stall, kill and the targets are combinational from IF/ID state plus rs_value/rs_ready/hold_in; no registered outputs beyond IF/ID and RAS.
- IF/ID update on rising clk:
  - stall: hold.
  - kill: load NOP_WORD, id_valid=0, id_npc=0.
  - else: load if_instruction, if_npc, id_valid=1.
- Redirect penalty: exactly one bubble. Taken instruction in ID at cycle n; fetch PC takes target at end of n; ID shows a bubble in n+1; target instruction reaches ID in n+2.
- RAS push and pop happen only on the clock edge at which a non-stalled, valid CALL/RET leaves ID.
- Full RAS (count==RAS_DEPTH) on CALL: overwrite the oldest entry (circular pointer wrap); count saturates.
- Empty RAS on RET:
  - ret_target=0; redirect still occurs.
  - Pointer and count unchanged.
  - ras_underflow set; cleared only by reset.
- reset_n asserted mid-stall or mid-redirect: immediate return to the reset state; no pending push/pop survives.

Decomposition:
- Shared package holds:
  - opcode constants (OP_JMP, OP_CALL, OP_RET, OP_BEQZ, OP_BNEZ).
  - PC_SRC_* 2-bit encodings shared with the fetch stage.
  - NOP_WORD default.
- One sub-module: return_address_stack (push/pop/top/empty/full, circular storage, saturating count).

Test Plan:
- Reset, then sequential ADD words at NPC 1,2,3 → pc_src=00, kill=0, each word appears in ID one cycle after fetch, id_valid=1.
- JMP 16'hC005 with id_npc=16'h1003 → j_target=16'h1005, pc_src=01, kill=1 for one cycle, ID bubble next cycle, word from 16'h1005 in ID the cycle after.
- BEQZ imm=6'b111110, id_npc=20, rs_ready=0 for 2 cycles then 1 with rs_value=0 → stall=1 for 2 cycles with ID held, then pc_src=10, i_target=18.
- CALL at id_npc=16'h0010, RET later → ret_target=16'h0010, pc_src=11; RAS empty afterwards.
- RAS_DEPTH=8: nine CALLs (npc 1..9), nine RETs → returns 9,8,…,2, then ninth RET gives ret_target=0 and ras_underflow=1.
- hold_in=1 concurrent with a JMP in ID → no kill, pc_src=00 until hold_in drops; reset_n pulse mid-hold → id_valid=0, ras_underflow=0 asynchronously.
